kbd_cmd_ctrl: RTL and testbench

- Registered successor to the combinational keyboard decoder. Accepts ASCII key codes from the keyboard interface, recognises the player commands E/D/F/B/R, and keeps the player control state: play/stop and forward/backward.
- Generates a stretched restart pulse.
- Sits between the keyboard receiver and the audio address/flash-read FSM.

---
 rtl/kbd_cmd_ctrl.sv | 109 ++++++++++
 tb/tb_kbd_cmd_ctrl.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/kbd_cmd_ctrl.sv
// Keyboard command controller: decodes E/D/F/B/R key codes into registered
// player state (play/stop, direction), a stretched restart pulse and
// per-key strobes. Every output comes straight from a flop or a flop compare.
module kbd_cmd_ctrl #(
  parameter int DATA_WIDTH       = 8,
  parameter bit CASE_INSENSITIVE = 1'b1,
  parameter bit CHANGE_DETECT    = 1'b0,
  parameter int RESTART_LEN      = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] kbd_data,
  input  logic                  kbd_valid,
  output logic                  play,
  output logic                  fwd,
  output logic                  restart,
  output logic                  cmd_strobe,
  output logic [2:0]            cmd_code,
  output logic                  unknown_strobe
);

  localparam int CW = $clog2(RESTART_LEN + 1);

  localparam logic [2:0] CMD_NONE = 3'd0;
  localparam logic [2:0] CMD_E    = 3'd1;
  localparam logic [2:0] CMD_D    = 3'd2;
  localparam logic [2:0] CMD_F    = 3'd3;
  localparam logic [2:0] CMD_B    = 3'd4;
  localparam logic [2:0] CMD_R    = 3'd5;

  typedef enum logic {STOPPED = 1'b0, PLAYING = 1'b1} state_t;

  state_t                state, state_nxt;
  logic [DATA_WIDTH-1:0] prev_data;
  logic                  sample;
  logic                  high_zero;
  logic [7:0]            key;
  logic [2:0]            key_cmd;
  logic [CW-1:0]         rcnt;

  // Previous-cycle key code, used to turn a held key into a single event
  always_ff @(posedge clk or posedge reset) begin
    if (reset) prev_data <= '0;
    else       prev_data <= kbd_data;
  end

  assign sample    = CHANGE_DETECT ? (kbd_data != prev_data) : kbd_valid;
  assign high_zero = (kbd_data >> 8) == '0;
  assign key       = kbd_data[7:0];

  // Key decode; anything outside the command set (or with high bits set) is unknown
  always_comb begin
    key_cmd = CMD_NONE;
    if (high_zero) begin
      case (key)
        8'h45: key_cmd = CMD_E;
        8'h44: key_cmd = CMD_D;
        8'h46: key_cmd = CMD_F;
        8'h42: key_cmd = CMD_B;
        8'h52: key_cmd = CMD_R;
        8'h65: if (CASE_INSENSITIVE) key_cmd = CMD_E;
        8'h64: if (CASE_INSENSITIVE) key_cmd = CMD_D;
        8'h66: if (CASE_INSENSITIVE) key_cmd = CMD_F;
        8'h62: if (CASE_INSENSITIVE) key_cmd = CMD_B;
        8'h72: if (CASE_INSENSITIVE) key_cmd = CMD_R;
        default: key_cmd = CMD_NONE;
      endcase
    end
  end

  // Play FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= STOPPED;
    else       state <= state_nxt;
  end

  // Play FSM next state: E starts, D stops, everything else holds
  always_comb begin
    state_nxt = state;
    if (sample) begin
      if (state == STOPPED && key_cmd == CMD_E)      state_nxt = PLAYING;
      else if (state == PLAYING && key_cmd == CMD_D) state_nxt = STOPPED;
    end
  end

  assign play    = (state == PLAYING);
  assign restart = (rcnt != '0);

  // Direction, restart counter, last command and strobes
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fwd            <= 1'b1;
      rcnt           <= '0;
      cmd_code       <= CMD_NONE;
      cmd_strobe     <= 1'b0;
      unknown_strobe <= 1'b0;
    end else begin
      cmd_strobe     <= sample && (key_cmd != CMD_NONE);
      unknown_strobe <= sample && (key_cmd == CMD_NONE);
      if (sample && key_cmd != CMD_NONE) cmd_code <= key_cmd;
      if (sample && key_cmd == CMD_F) fwd <= 1'b1;
      if (sample && key_cmd == CMD_B) fwd <= 1'b0;
      // A new R reloads, so an active pulse is extended rather than cut short
      if (sample && key_cmd == CMD_R) rcnt <= CW'(RESTART_LEN);
      else if (rcnt != '0)            rcnt <= rcnt - CW'(1);
    end
  end

endmodule

// File: tb/tb_kbd_cmd_ctrl.sv
// Bench for kbd_cmd_ctrl: three instances (default, upper-case only,
// change-detect) checked every cycle against a behavioural model, plus
// literal spot checks along a directed key sequence.
module tb_kbd_cmd_ctrl;
  localparam int LEN = 4;

  logic       clk, reset;
  logic [7:0] din [3];
  logic       vin [3];
  logic       o_play [3], o_fwd [3], o_rst [3], o_cs [3], o_us [3];
  logic [2:0] o_code [3];

  int n_cmp = 0, n_err = 0;
  bit run_chk = 0;

  kbd_cmd_ctrl #(.DATA_WIDTH(8), .CASE_INSENSITIVE(1'b1), .CHANGE_DETECT(1'b0), .RESTART_LEN(LEN)) u_a (
    .clk(clk), .reset(reset), .kbd_data(din[0]), .kbd_valid(vin[0]),
    .play(o_play[0]), .fwd(o_fwd[0]), .restart(o_rst[0]), .cmd_strobe(o_cs[0]),
    .cmd_code(o_code[0]), .unknown_strobe(o_us[0]));
  kbd_cmd_ctrl #(.DATA_WIDTH(8), .CASE_INSENSITIVE(1'b0), .CHANGE_DETECT(1'b0), .RESTART_LEN(LEN)) u_b (
    .clk(clk), .reset(reset), .kbd_data(din[1]), .kbd_valid(vin[1]),
    .play(o_play[1]), .fwd(o_fwd[1]), .restart(o_rst[1]), .cmd_strobe(o_cs[1]),
    .cmd_code(o_code[1]), .unknown_strobe(o_us[1]));
  kbd_cmd_ctrl #(.DATA_WIDTH(8), .CASE_INSENSITIVE(1'b1), .CHANGE_DETECT(1'b1), .RESTART_LEN(LEN)) u_c (
    .clk(clk), .reset(reset), .kbd_data(din[2]), .kbd_valid(vin[2]),
    .play(o_play[2]), .fwd(o_fwd[2]), .restart(o_rst[2]), .cmd_strobe(o_cs[2]),
    .cmd_code(o_code[2]), .unknown_strobe(o_us[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit ci_of(input int i); return i != 1; endfunction
  function automatic bit cd_of(input int i); return i == 2; endfunction

  // Command number 1..5 for E,D,F,B,R; 0 for anything else
  function automatic int decode(input logic [7:0] k, input bit ci);
    logic [7:0] u;
    logic [7:0] cmds [5];
    cmds = '{8'h45, 8'h44, 8'h46, 8'h42, 8'h52};
    u = k;
    if (ci && k >= 8'h61 && k <= 8'h7a) u = k - 8'd32;
    for (int j = 0; j < 5; j++) if (u == cmds[j]) return j + 1;
    return 0;
  endfunction

  // Behavioural model: restart is tracked as an end cycle, not a counter
  logic [7:0] m_prev [3];
  bit         m_play [3], m_fwd [3], m_cs [3], m_us [3];
  int         m_code [3], m_rend [3];
  int         cyc = 0;
  bit         ev_t;
  int         c_t;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 3; i++) begin
        m_prev[i] = 0; m_play[i] = 0; m_fwd[i] = 1; m_cs[i] = 0; m_us[i] = 0;
        m_code[i] = 0; m_rend[i] = -1;
      end
    end else begin
      cyc++;
      for (int i = 0; i < 3; i++) begin
        ev_t = cd_of(i) ? (din[i] != m_prev[i]) : vin[i];
        c_t  = decode(din[i], ci_of(i));
        m_prev[i] = din[i];
        m_cs[i] = ev_t && c_t != 0;
        m_us[i] = ev_t && c_t == 0;
        if (ev_t && c_t != 0) begin
          m_code[i] = c_t;
          case (c_t)
            1: m_play[i] = 1;
            2: m_play[i] = 0;
            3: m_fwd[i] = 1;
            4: m_fwd[i] = 0;
            default: m_rend[i] = cyc + LEN - 1;
          endcase
        end
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (run_chk && !reset) begin
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("play[%0d]", i), o_play[i], m_play[i]);
        chk($sformatf("fwd[%0d]", i), o_fwd[i], m_fwd[i]);
        chk($sformatf("restart[%0d]", i), o_rst[i], (cyc <= m_rend[i]) ? 1 : 0);
        chk($sformatf("cmd_strobe[%0d]", i), o_cs[i], m_cs[i]);
        chk($sformatf("unknown_strobe[%0d]", i), o_us[i], m_us[i]);
        chk($sformatf("cmd_code[%0d]", i), o_code[i], m_code[i]);
      end
    end
  end

  // Strobe a key into the two kbd_valid-driven instances; returns in the
  // cycle where the registered outputs reflect it
  task automatic send(input logic [7:0] k);
    @(negedge clk);
    din[0] = k; din[1] = k; vin[0] = 1; vin[1] = 1; vin[2] = 1;
    @(negedge clk);
    vin[0] = 0; vin[1] = 0; vin[2] = 0;
  endtask

  task automatic check_reset_vals(input string tag);
    for (int i = 0; i < 3; i++) begin
      chk({tag, "_play"}, o_play[i], 0);
      chk({tag, "_fwd"}, o_fwd[i], 1);
      chk({tag, "_restart"}, o_rst[i], 0);
      chk({tag, "_cs"}, o_cs[i], 0);
      chk({tag, "_us"}, o_us[i], 0);
      chk({tag, "_code"}, o_code[i], 0);
    end
  endtask

  int cnt;

  initial begin
    reset = 1;
    for (int i = 0; i < 3; i++) begin din[i] = 0; vin[i] = 0; end
    repeat (2) @(negedge clk);
    check_reset_vals("reset");
    reset = 0;
    run_chk = 1;

    // Unknown key
    send(8'h7a);
    chk("z_us", o_us[0], 1); chk("z_cs", o_cs[0], 0);
    chk("z_play", o_play[0], 0); chk("z_fwd", o_fwd[0], 1); chk("z_code", o_code[0], 0);
    @(negedge clk);
    chk("z_us_drop", o_us[0], 0);

    // Lower-case e: command on u_a, unknown on upper-case-only u_b
    send(8'h65);
    chk("e_play", o_play[0], 1); chk("e_code", o_code[0], 1); chk("e_cs", o_cs[0], 1);
    chk("e_b_us", o_us[1], 1); chk("e_b_play", o_play[1], 0);
    send(8'h44);
    chk("d_play", o_play[0], 0); chk("d_code", o_code[0], 2);

    // Direction
    send(8'h45);
    send(8'h42);
    chk("b_fwd", o_fwd[0], 0); chk("b_code", o_code[0], 4); chk("b_play", o_play[0], 1);
    send(8'h66);
    chk("f_fwd", o_fwd[0], 1); chk("f_code", o_code[0], 3); chk("f_play", o_play[0], 1);
    chk("f_b_fwd", o_fwd[1], 0);

    // Back-to-back keys with valid held high
    @(negedge clk);
    din[0] = 8'h42; din[1] = 8'h42; vin[0] = 1; vin[1] = 1;
    @(negedge clk); din[0] = 8'h44; din[1] = 8'h44;
    @(negedge clk); din[0] = 8'h46; din[1] = 8'h46;
    @(negedge clk); vin[0] = 0; vin[1] = 0;
    chk("b2b_fwd", o_fwd[0], 1); chk("b2b_play", o_play[0], 0); chk("b2b_code", o_code[0], 3);

    // Single R: high for exactly LEN cycles
    send(8'h52);
    for (int k = 1; k <= LEN + 1; k++) begin
      chk($sformatf("r1_c%0d", k), o_rst[0], (k <= LEN) ? 1 : 0);
      @(negedge clk);
    end

    // Second R two cycles after the first extends the pulse through t+6
    send(8'h52);                 // now in cycle t+1
    @(negedge clk);              // t+2: present second R
    din[0] = 8'h52; din[1] = 8'h52; vin[0] = 1; vin[1] = 1;
    chk("r2_t2", o_rst[0], 1);
    @(negedge clk); vin[0] = 0; vin[1] = 0;
    for (int k = 3; k <= 7; k++) begin
      chk($sformatf("r2_t%0d", k), o_rst[0], (k <= 6) ? 1 : 0);
      @(negedge clk);
    end

    // Change-detect instance: a held key is one event
    cnt = 0;
    @(negedge clk); din[2] = 8'h45;
    repeat (10) begin @(negedge clk); if (o_cs[2]) cnt++; end
    chk("cd_hold_strobes", cnt, 1); chk("cd_hold_play", o_play[2], 1);
    cnt = 0;
    din[2] = 8'h44;
    repeat (3) begin @(negedge clk); if (o_cs[2]) cnt++; end
    chk("cd_d_strobes", cnt, 1); chk("cd_d_play", o_play[2], 0);
    cnt = 0;
    din[2] = 8'h45;
    @(negedge clk); if (o_cs[2]) cnt++; din[2] = 8'h44;
    @(negedge clk); if (o_cs[2]) cnt++; din[2] = 8'h45;
    repeat (3) begin @(negedge clk); if (o_cs[2]) cnt++; end
    chk("cd_seq_strobes", cnt, 3); chk("cd_seq_play", o_play[2], 1);

    // Async reset mid-pulse while playing
    send(8'h45);
    send(8'h52);
    @(negedge clk);
    chk("pre_rst_play", o_play[0], 1); chk("pre_rst_restart", o_rst[0], 1);
    #2 reset = 1;
    #1 check_reset_vals("async_rst");
    @(negedge clk);
    reset = 0;
    din[0] = 0; din[1] = 0; din[2] = 0;
    repeat (3) @(negedge clk);

    run_chk = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
